// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared single-port packet
// buffer RAM. One requester is granted at a time; the arbiter then drives the
// RAM for BURST_LEN consecutive beats starting at the latched base address.
module mem_access_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 19
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_rd,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              wr_beat,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BURST,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       win_idx;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic                   op_wr;
    logic [BEAT_W-1:0]      beat;
    logic                   last_beat;
    logic                   rd_beat;

    logic [NUM_REQ-1:0]     req_any;
    logic [NUM_REQ-1:0]     win_onehot;
    logic                   cand_found;
    logic [IDX_W-1:0]       cand_idx;
    logic [IDX_W-1:0]       pos_idx;
    int unsigned            pos;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    assign req_any   = req_rd | req_wr;
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
    assign rd_beat   = (state == S_BURST) && !op_wr;

    // Unpack the flat per-requester address and write-data buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first requester at or above rr_ptr, with wrap
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        pos        = 0;
        pos_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (!cand_found && req_any[pos_idx]) begin
                cand_found = 1'b1;
                cand_idx   = pos_idx;
            end
        end
    end

    // One-hot form of the latched winner, shared by all per-requester outputs
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cand_found) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_BURST;
            S_BURST: if (last_beat) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transaction context: winner, base address, operation, pointer, beat count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            win_idx   <= '0;
            base_addr <= '0;
            op_wr     <= 1'b0;
            beat      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    beat <= '0;
                    if (cand_found) begin
                        win_idx   <= cand_idx;
                        base_addr <= addr_arr[cand_idx];
                        // write wins when a requester raises both
                        op_wr     <= req_wr[cand_idx];
                    end
                end
                S_GRANT: begin
                    if (win_idx == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= win_idx + 1'b1;
                    end
                end
                S_BURST: begin
                    if (last_beat) begin
                        beat <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: beat <= '0;
            endcase
        end
    end

    // Combinational handshake and RAM drive, all zero outside their states
    always_comb begin
        gnt       = '0;
        wr_beat   = '0;
        done      = '0;
        busy      = (state != S_IDLE);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_GRANT: gnt = win_onehot;
            S_BURST: begin
                mem_en   = 1'b1;
                // address add is truncated so bursts wrap at the top of RAM
                mem_addr = base_addr + ADDR_WIDTH'(beat);
                if (op_wr) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_arr[win_idx];
                    wr_beat   = win_onehot;
                end
            end
            S_DONE:  done = win_onehot;
            default: ;
        endcase
    end

    // Read return: mem_rdata is captured on the edge that closes each read
    // beat, so rd_valid/rd_data follow the beat by exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else if (rd_beat) begin
            rd_valid <= win_onehot;
            rd_data  <= mem_rdata;
        end else begin
            rd_valid <= '0;
            rd_data  <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: stimulus pushes expected grants,
// beats, read returns and completions; a negedge monitor pops and compares.
module tb_mem_access_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BL = 19;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_rd;
    logic [NR-1:0]     req_wr;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     wr_beat;
    logic [NR-1:0]     rd_valid;
    logic [DW-1:0]     rd_data;
    logic [NR-1:0]     done;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    mem_access_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .wr_beat   (wr_beat),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // RAM model: preloaded with word = address, combinational read
    logic [DW-1:0] ram [1024];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int           cyc;
        logic [NR-1:0] oh;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
        logic          rdv;
    } exp_t;

    exp_t gnt_q[$];
    exp_t beat_q[$];
    exp_t rd_q[$];
    exp_t done_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic unexpected(input string nm, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output %0h, nothing expected (cycle %0d)", nm, act, cyc);
    endtask

    function automatic logic [NR-1:0] onehot(input int r);
        return NR'(1) << r;
    endfunction

    // Monitor: pop and compare whenever the DUT presents an output
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) unexpected("gnt", gnt);
                else begin
                    e = gnt_q.pop_front();
                    chk("gnt", gnt, e.oh);
                    chk("gnt_cycle", cyc, e.cyc);
                    chk("busy_at_gnt", busy, 1);
                end
            end
            if (mem_en) begin
                if (beat_q.size() == 0) unexpected("beat", mem_addr);
                else begin
                    e = beat_q.pop_front();
                    chk("beat_cycle", cyc, e.cyc);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", mem_we, e.we);
                    chk("wr_beat", wr_beat, e.we ? e.oh : '0);
                    if (e.we) chk("mem_wdata", mem_wdata, e.data);
                end
            end else begin
                chk("idle_mem_outputs", {mem_we, mem_addr, mem_wdata, wr_beat}, '0);
            end
            if (rd_valid != '0) begin
                if (rd_q.size() == 0) unexpected("rd_valid", rd_valid);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_valid", rd_valid, e.oh);
                    chk("rd_data", rd_data, e.data);
                end
            end else begin
                chk("rd_data_idle", rd_data, '0);
            end
            if (done != '0) begin
                if (done_q.size() == 0) unexpected("done", done);
                else begin
                    e = done_q.pop_front();
                    chk("done", done, e.oh);
                    chk("done_cycle", cyc, e.cyc);
                    chk("rd_valid_at_done", rd_valid, e.rdv ? e.oh : '0);
                end
            end
        end
    end

    // Expected events of one burst sampled in IDLE at cycle t
    task automatic push_burst(input int r, input bit wr, input logic [AW-1:0] base,
                              input logic [DW-1:0] wd, input int t, input int nbeats,
                              input bit with_done);
        exp_t e;
        e.oh = onehot(r); e.we = wr; e.data = wd; e.addr = base; e.rdv = !wr;
        e.cyc = t + 1;
        gnt_q.push_back(e);
        for (int b = 0; b < nbeats; b++) begin
            e.addr = base + AW'(b);
            e.data = wd;
            e.cyc  = t + 2 + b;
            beat_q.push_back(e);
            if (!wr) begin
                e.data = DW'(e.addr);
                e.cyc  = t + 3 + b;
                rd_q.push_back(e);
            end
        end
        if (with_done) begin
            e.cyc = t + 2 + BL;
            done_q.push_back(e);
        end
    endtask

    task automatic set_req(input int r, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = wd;
        req_rd[r] = rd;
        req_wr[r] = wr;
    endtask

    // Wait (bounded) for gnt (which=0) or done (which=1)
    task automatic wait_out(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((which == 0 ? gnt : done) != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) unexpected(which == 0 ? "timeout_gnt" : "timeout_done", 0);
    endtask

    // Serve n grants: drop the winner's request on gnt, optionally re-raise it after done
    task automatic run_grants(input int n, input bit reassert);
        bit ok;
        int r;
        logic rb, wb;
        for (int k = 0; k < n; k++) begin
            wait_out(0, ok);
            if (!ok) return;
            r = 0;
            for (int i = 0; i < NR; i++) if (gnt[i]) r = i;
            rb = req_rd[r]; wb = req_wr[r];
            req_rd[r] = 1'b0; req_wr[r] = 1'b0;
            if (k == n - 1) begin
                req_rd = '0; req_wr = '0;
            end
            wait_out(1, ok);
            if (!ok) return;
            if (reassert && k < n - 1) begin
                req_rd[r] = rb; req_wr[r] = wb;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, gnt, '0);
        chk({tag, "_wr_beat"}, wr_beat, '0);
        chk({tag, "_rd_valid"}, rd_valid, '0);
        chk({tag, "_rd_data"}, rd_data, '0);
        chk({tag, "_done"}, done, '0);
        chk({tag, "_busy"}, busy, '0);
        chk({tag, "_mem_en"}, mem_en, '0);
        chk({tag, "_mem_we"}, mem_we, '0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    // Write from requester r, asynchronous reset asserted during beat b
    task automatic abort_write(input int r, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input int b);
        bit ok;
        int t;
        set_req(r, 0, 1, a, wd);
        t = cyc;
        push_burst(r, 1, a, wd, t, b + 1, 0);
        wait_out(0, ok);
        req_wr = '0;
        for (int i = 0; i < 100 && cyc != t + 2 + b; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        chk("queues_drained", gnt_q.size() + beat_q.size() + rd_q.size() + done_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) ram[i] = DW'(i);
        req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Contention from reset: requesters 0, 2, 3 -> order 0, 2, 3, 0
        set_req(0, 0, 1, 10'h200, 64'hD000_0000_0000_1000);
        set_req(2, 0, 1, 10'h280, 64'hD000_0000_0000_3000);
        set_req(3, 0, 1, 10'h300, 64'hD000_0000_0000_4000);
        t = cyc;
        push_burst(0, 1, 10'h200, 64'hD000_0000_0000_1000, t, BL, 1);
        push_burst(2, 1, 10'h280, 64'hD000_0000_0000_3000, t + (BL + 3), BL, 1);
        push_burst(3, 1, 10'h300, 64'hD000_0000_0000_4000, t + 2 * (BL + 3), BL, 1);
        push_burst(0, 1, 10'h200, 64'hD000_0000_0000_1000, t + 3 * (BL + 3), BL, 1);
        run_grants(4, 1);

        // Single write from requester 1 at 0x040
        set_req(1, 0, 1, 10'h040, 64'hCAFE_F00D_1234_5678);
        t = cyc;
        push_burst(1, 1, 10'h040, 64'hCAFE_F00D_1234_5678, t, BL, 1);
        run_grants(1, 0);

        // Single read from requester 2 at 0x100
        set_req(2, 1, 0, 10'h100, '0);
        t = cyc;
        push_burst(2, 0, 10'h100, '0, t, BL, 1);
        run_grants(1, 0);

        // Read wrapping past the top of RAM
        set_req(1, 1, 0, 10'h3F8, '0);
        t = cyc;
        push_burst(1, 0, 10'h3F8, '0, t, BL, 1);
        run_grants(1, 0);

        // Read and write together: write wins
        set_req(0, 1, 1, 10'h020, 64'h0123_4567_89AB_CDEF);
        t = cyc;
        push_burst(0, 1, 10'h020, 64'h0123_4567_89AB_CDEF, t, BL, 1);
        run_grants(1, 0);

        // Reset at beat 5 of a write, then requester 3 alone
        abort_write(2, 10'h1C0, 64'h5555_AAAA_5555_AAAA, 5);
        set_req(3, 0, 1, 10'h1C0, 64'h7777_8888_9999_0000);
        t = cyc;
        push_burst(3, 1, 10'h1C0, 64'h7777_8888_9999_0000, t, BL, 1);
        run_grants(1, 0);

        // Pointer returns to 0 on reset: after aborting requester 1, 0 beats 3
        abort_write(1, 10'h180, 64'h1111_2222_3333_4444, 2);
        set_req(0, 0, 1, 10'h240, 64'hABCD_0000_0000_0001);
        set_req(3, 1, 0, 10'h0C0, '0);
        t = cyc;
        push_burst(0, 1, 10'h240, 64'hABCD_0000_0000_0001, t, BL, 1);
        push_burst(3, 0, 10'h0C0, '0, t + BL + 3, BL, 1);
        run_grants(2, 0);

        chk("leftover_expectations", gnt_q.size() + beat_q.size() + rd_q.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
